// File: rtl/flag_branch_sequencer.sv
// Purpose : program-counter sequencer; steers fetch with flag-qualified absolute/relative branches.
// Latency : ProgCtr/Ack/Taken/CycleCnt are registered (1 cycle); Running decodes state combinationally.
// Backpr. : none; the Start/Ack handshake gates runs, and strobes outside RUN are ignored.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   Start, StartAddr    run request and PC load value (IDLE/DONE)
//   Halt, BranchAbs,    decoder strobes, priority Halt > BranchAbs > BranchRel
//   BranchRel
//   FlagIn              condition flag, read in the same cycle as the strobe
//   Target, Offset      absolute destination / signed relative offset
//   ProgCtr, Ack,       current PC, run-complete, previous RUN cycle branched,
//   Taken, CycleCnt,    saturating RUN-cycle count,
//   Running             high while in RUN
module flag_branch_sequencer #(
    parameter int PW = 10,
    parameter int OW = 6,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Halt,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic          FlagIn,
    input  logic [PW-1:0] Target,
    input  logic [OW-1:0] Offset,
    output logic [PW-1:0] ProgCtr,
    output logic          Ack,
    output logic          Running,
    output logic          Taken,
    output logic [CW-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          ack_q, ack_d;
    logic          taken_q, taken_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;

    // Offset is sign-extended to PC width so the add wraps modulo 2^PW.
    logic [PW-1:0] off_ext;
    logic [PW-1:0] pc_inc;
    logic [CW-1:0] cnt_inc;

    assign off_ext = {{(PW-OW){Offset[OW-1]}}, Offset};
    assign pc_inc  = pc_q + {{(PW-1){1'b0}}, 1'b1};
    // Counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ack_q   <= 1'b0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ack_q   <= ack_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ack_d   = ack_q;
        taken_d = taken_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    taken_d = 1'b0;
                    seen_d  = 1'b1;
                end else if (seen_q) begin
                    // Falling edge of a seen Start launches the run.
                    state_d = S_RUN;
                    seen_d  = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (Halt) begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                    taken_d = 1'b0;
                end else if (BranchAbs && FlagIn) begin
                    pc_d    = Target;
                    taken_d = 1'b1;
                end else if (BranchRel && FlagIn) begin
                    pc_d    = pc_q + off_ext;
                    taken_d = 1'b1;
                end else begin
                    pc_d    = pc_inc;
                    taken_d = 1'b0;
                end
            end
            S_DONE: begin
                if (Start) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                    seen_d  = 1'b1;
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    taken_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ProgCtr  = pc_q;
    assign Ack      = ack_q;
    assign Taken    = taken_q;
    assign CycleCnt = cnt_q;
    assign Running  = (state_q == S_RUN);

endmodule
